// File: rtl/fault_inject_master_pkg.sv
// Shared definitions for the fault-injection AXI4-Lite master and the slave it
// targets: bus widths, command op codes, FSM state encoding, slave sub-selector
// constants and AXI response codes.
package fault_inject_master_pkg;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int DATA_WIDTH     = 32;
   localparam int STRB_WIDTH     = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_FLIP  = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      RD_ADDR      = 3'd1,
      RD_DATA      = 3'd2,
      WR_ADDR_DATA = 3'd3,
      WR_RESP      = 3'd4,
      RSP          = 3'd5
   } state_e;

   // Slave sub-selector, carried in address bits [15:8].
   localparam logic [7:0] SEL_REGISTER_FILE = 8'h00;
   localparam logic [7:0] SEL_PC            = 8'h01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/fault_inject_master_if.sv
// AXI4-Lite bus between the fault-injection master and its slave.
// Channels: AW (addr/prot/valid/ready), W (data/strb/valid/ready),
// B (resp/valid/ready), AR (addr/prot/valid/ready), R (data/resp/valid/ready).
// Modports: master (drives AW/W/AR, BREADY, RREADY) and slave (the reverse).
interface fault_inject_master_if;
   import fault_inject_master_pkg::*;

   logic [AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
   logic [2:0]                M_AXI_AWPROT;
   logic                      M_AXI_AWVALID;
   logic                      M_AXI_AWREADY;

   logic [DATA_WIDTH-1:0]     M_AXI_WDATA;
   logic [STRB_WIDTH-1:0]     M_AXI_WSTRB;
   logic                      M_AXI_WVALID;
   logic                      M_AXI_WREADY;

   logic [1:0]                M_AXI_BRESP;
   logic                      M_AXI_BVALID;
   logic                      M_AXI_BREADY;

   logic [AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
   logic [2:0]                M_AXI_ARPROT;
   logic                      M_AXI_ARVALID;
   logic                      M_AXI_ARREADY;

   logic [DATA_WIDTH-1:0]     M_AXI_RDATA;
   logic [1:0]                M_AXI_RRESP;
   logic                      M_AXI_RVALID;
   logic                      M_AXI_RREADY;

   modport master (
      output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BRESP, M_AXI_BVALID,
      output M_AXI_BREADY,
      output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
      input  M_AXI_ARREADY,
      input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      output M_AXI_RREADY
   );

   modport slave (
      input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BRESP, M_AXI_BVALID,
      input  M_AXI_BREADY,
      input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
      output M_AXI_ARREADY,
      output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      input  M_AXI_RREADY
   );

endinterface

// File: rtl/fault_inject_master.sv
// Fault-injection AXI4-Lite master. Takes one command at a time (READ, WRITE,
// or FLIP = read, XOR with a mask, write back) and reports one response.
// Ports:
//   CLK, RSTn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op, cmd_addr, cmd_wdata, cmd_mask
//   rsp_valid/rsp_ready        response handshake; rsp_data, rsp_err
//   m_axi                      AXI4-Lite master port
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | ready for a command
// RD_ADDR      | ARVALID up, waiting for ARREADY
// RD_DATA      | RREADY up, waiting for RVALID
// WR_ADDR_DATA | AWVALID/WVALID up, each dropped after its own handshake
// WR_RESP      | BREADY up, waiting for BVALID
// RSP          | rsp_valid up, waiting for rsp_ready
module fault_inject_master
   import fault_inject_master_pkg::*;
#(
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic                      CLK,
   input  logic                      RSTn,

   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH-1:0]     cmd_mask,

   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_data,
   output logic                      rsp_err,

   fault_inject_master_if.master     m_axi
);

   state_e                    state_q, state_d;
   op_e                       op_q;
   op_e                       cmd_op_e;
   logic [AXI_ADDR_WIDTH-1:0] axi_addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH-1:0]     mask_q;
   logic [DATA_WIDTH-1:0]     rsp_data_q;
   logic                      rsp_err_q;
   logic                      aw_done_q;
   logic                      w_done_q;

   logic cmd_hs, r_hs, b_hs;
   logic aw_valid, w_valid, aw_hs, w_hs, aw_ok, w_ok;

   assign cmd_op_e = op_e'(cmd_op);

   assign cmd_hs   = (state_q == IDLE) && cmd_valid;
   assign r_hs     = (state_q == RD_DATA) && m_axi.M_AXI_RVALID;
   assign b_hs     = (state_q == WR_RESP) && m_axi.M_AXI_BVALID;
   assign aw_valid = (state_q == WR_ADDR_DATA) && !aw_done_q;
   assign w_valid  = (state_q == WR_ADDR_DATA) && !w_done_q;
   assign aw_hs    = aw_valid && m_axi.M_AXI_AWREADY;
   assign w_hs     = w_valid && m_axi.M_AXI_WREADY;
   // A channel counts as finished if it completed earlier or completes now.
   assign aw_ok    = aw_done_q || aw_hs;
   assign w_ok     = w_done_q || w_hs;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               unique case (cmd_op_e)
                  OP_READ, OP_FLIP: state_d = RD_ADDR;
                  OP_WRITE:         state_d = WR_ADDR_DATA;
                  default:          state_d = RSP;
               endcase
            end
         end
         RD_ADDR: begin
            if (m_axi.M_AXI_ARREADY) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (m_axi.M_AXI_RVALID) begin
               if ((op_q == OP_FLIP) && !resp_is_err(m_axi.M_AXI_RRESP)) begin
                  state_d = WR_ADDR_DATA;
               end else begin
                  state_d = RSP;
               end
            end
         end
         WR_ADDR_DATA: begin
            if (aw_ok && w_ok) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (m_axi.M_AXI_BVALID) state_d = RSP;
         end
         RSP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         op_q       <= OP_READ;
         axi_addr_q <= '0;
         wdata_q    <= '0;
         mask_q     <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         if (cmd_hs) begin
            op_q       <= cmd_op_e;
            axi_addr_q <= cmd_addr | BASE_ADDR;
            wdata_q    <= cmd_wdata;
            mask_q     <= cmd_mask;
            rsp_data_q <= '0;
            rsp_err_q  <= (cmd_op_e == OP_RSVD);
         end
         // READ and FLIP both report the original value; FLIP's error flag is
         // refined by the write response if the write goes ahead.
         if (r_hs) begin
            rsp_data_q <= m_axi.M_AXI_RDATA;
            rsp_err_q  <= resp_is_err(m_axi.M_AXI_RRESP);
            if (op_q == OP_FLIP) wdata_q <= m_axi.M_AXI_RDATA ^ mask_q;
         end
         if (state_q == WR_ADDR_DATA) begin
            if (aw_ok && w_ok) begin
               aw_done_q <= 1'b0;
               w_done_q  <= 1'b0;
            end else begin
               if (aw_hs) aw_done_q <= 1'b1;
               if (w_hs)  w_done_q  <= 1'b1;
            end
         end
         if (b_hs) rsp_err_q <= resp_is_err(m_axi.M_AXI_BRESP);
      end
   end

   // Everything below decodes registered state only; cmd_ready is additionally
   // gated so it reads 0 while reset is held.
   always_comb begin
      cmd_ready           = RSTn && (state_q == IDLE);
      rsp_valid           = (state_q == RSP);
      rsp_data            = rsp_data_q;
      rsp_err             = rsp_err_q;

      m_axi.M_AXI_ARVALID = (state_q == RD_ADDR);
      m_axi.M_AXI_ARADDR  = axi_addr_q;
      m_axi.M_AXI_ARPROT  = 3'b000;
      m_axi.M_AXI_RREADY  = (state_q == RD_DATA);

      m_axi.M_AXI_AWVALID = aw_valid;
      m_axi.M_AXI_AWADDR  = axi_addr_q;
      m_axi.M_AXI_AWPROT  = 3'b000;
      m_axi.M_AXI_WVALID  = w_valid;
      m_axi.M_AXI_WDATA   = wdata_q;
      m_axi.M_AXI_WSTRB   = {STRB_WIDTH{state_q == WR_ADDR_DATA}};
      m_axi.M_AXI_BREADY  = (state_q == WR_RESP);
   end

endmodule

// File: tb/tb_fault_inject_master.sv
`timescale 1ns/1ps
module tb_fault_inject_master;
   import fault_inject_master_pkg::*;

   localparam logic [31:0] PC_VALUE = 32'h0000_0200;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [31:0] cmd_mask = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;

   fault_inject_master_if axi ();

   fault_inject_master #(.BASE_ADDR(32'h4000_0000)) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_mask  (cmd_mask),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .m_axi     (axi.master)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Slave controls (written by the main sequence only) and observations
   // (written by the slave only).
   int          aw_hold = 1;
   int          w_hold = 1;
   bit          r_hold = 1'b0;
   int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   int          aw_last_cycles = 0, w_last_cycles = 0;
   logic [31:0] last_araddr = '0;
   logic [31:0] regs [0:31];

   // Slave model: acts on the falling edge. A handshake noticed at one falling
   // edge fires at the next rising edge and is retired at the falling edge after.
   initial begin : slave
      bit          ar_pend, r_pend, aw_pend, w_pend, b_pend;
      bit          r_queued, aw_got, w_got;
      int          aw_seen, w_seen;
      logic [31:0] ar_cap, aw_cap, wd_cap, rd_q;
      logic [1:0]  rr_q;
      logic [7:0]  sel, sub;
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      regs[5] = 32'hDEAD_BEEF;
      regs[7] = 32'h0000_00F0;
      {ar_pend, r_pend, aw_pend, w_pend, b_pend, r_queued, aw_got, w_got} = '0;
      aw_seen = 0; w_seen = 0;
      ar_cap = '0; aw_cap = '0; wd_cap = '0; rd_q = '0; rr_q = '0;
      axi.M_AXI_ARREADY = 1'b0; axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0;
      axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RDATA = '0; axi.M_AXI_RRESP = '0;
      axi.M_AXI_BVALID = 1'b0; axi.M_AXI_BRESP = '0;
      forever begin
         @(negedge CLK);
         if (!RSTn) begin
            {ar_pend, r_pend, aw_pend, w_pend, b_pend, r_queued, aw_got, w_got} = '0;
            aw_seen = 0; w_seen = 0;
            axi.M_AXI_ARREADY = 1'b0; axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0;
            axi.M_AXI_RVALID = 1'b0; axi.M_AXI_BVALID = 1'b0;
         end else begin
            if (ar_pend) begin
               ar_cnt++;
               axi.M_AXI_ARREADY = 1'b0;
               last_araddr = ar_cap;
               sel = ar_cap[15:8];
               sub = ar_cap[7:0];
               if (sel == SEL_REGISTER_FILE && sub < 8'd32) begin
                  rd_q = (sub == 8'd0) ? 32'h0 : regs[sub[4:0]];
                  rr_q = RESP_OKAY;
               end else if (sel == SEL_PC) begin
                  rd_q = PC_VALUE;
                  rr_q = RESP_SLVERR;
               end else begin
                  rd_q = 32'hBAD0_BAD0;
                  rr_q = RESP_SLVERR;
               end
               r_queued = 1'b1;
            end
            if (r_pend) begin
               r_cnt++;
               axi.M_AXI_RVALID = 1'b0;
            end
            if (aw_pend) begin
               aw_cnt++;
               axi.M_AXI_AWREADY = 1'b0;
               aw_got = 1'b1;
               aw_last_cycles = aw_seen;
               aw_seen = 0;
            end
            if (w_pend) begin
               w_cnt++;
               axi.M_AXI_WREADY = 1'b0;
               w_got = 1'b1;
               w_last_cycles = w_seen;
               w_seen = 0;
            end
            if (b_pend) begin
               b_cnt++;
               axi.M_AXI_BVALID = 1'b0;
            end
            if (aw_got && w_got) begin
               sel = aw_cap[15:8];
               sub = aw_cap[7:0];
               if (sel == SEL_REGISTER_FILE && sub < 8'd32 && sub != 8'd0) begin
                  regs[sub[4:0]] = wd_cap;
                  axi.M_AXI_BRESP = RESP_OKAY;
               end else begin
                  axi.M_AXI_BRESP = RESP_SLVERR;
               end
               axi.M_AXI_BVALID = 1'b1;
               aw_got = 1'b0;
               w_got = 1'b0;
            end
            if (r_queued && !r_hold && !axi.M_AXI_RVALID) begin
               axi.M_AXI_RVALID = 1'b1;
               axi.M_AXI_RDATA = rd_q;
               axi.M_AXI_RRESP = rr_q;
               r_queued = 1'b0;
            end
            if (axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY) axi.M_AXI_ARREADY = 1'b1;
            if (axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY) begin
               aw_seen++;
               if (aw_seen >= aw_hold) axi.M_AXI_AWREADY = 1'b1;
            end
            if (axi.M_AXI_WVALID && !axi.M_AXI_WREADY) begin
               w_seen++;
               if (w_seen >= w_hold) axi.M_AXI_WREADY = 1'b1;
            end
         end
         ar_pend = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
         if (ar_pend) ar_cap = axi.M_AXI_ARADDR;
         r_pend  = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
         aw_pend = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
         if (aw_pend) aw_cap = axi.M_AXI_AWADDR;
         w_pend  = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
         if (w_pend) wd_cap = axi.M_AXI_WDATA;
         b_pend  = axi.M_AXI_BVALID && axi.M_AXI_BREADY;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one command, waits for the response, holds rsp_ready low for
   // rsp_delay cycles (noting whether the response stayed put), then consumes it.
   task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mask,
                          input int rsp_delay, output logic [31:0] data,
                          output logic err, output bit timeout, output bit held);
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask;
      @(negedge CLK);
      cmd_valid = 1'b0;
      timeout = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (rsp_valid) begin
            timeout = 1'b0;
            break;
         end
         @(negedge CLK);
      end
      data = rsp_data;
      err = rsp_err;
      held = 1'b1;
      if (!timeout) begin
         for (int i = 0; i < rsp_delay; i++) begin
            @(negedge CLK);
            if (!rsp_valid || rsp_data !== data || rsp_err !== err) held = 1'b0;
         end
         rsp_ready = 1'b1;
         @(negedge CLK);
         rsp_ready = 1'b0;
      end
   endtask

   function automatic logic [31:0] valids();
      return 32'({axi.M_AXI_ARVALID, axi.M_AXI_RREADY, axi.M_AXI_AWVALID,
                  axi.M_AXI_WVALID, axi.M_AXI_BREADY, rsp_valid, rsp_err});
   endfunction

   initial begin : main
      logic [31:0] d;
      logic        e;
      bit          to, held;
      int          ar0, r0, aw0, w0, b0, seen;

      repeat (2) @(negedge CLK);
      check("reset valids", valids(), 32'h0);
      check("reset cmd_ready", 32'(cmd_ready), 32'h0);
      check("reset araddr", axi.M_AXI_ARADDR, 32'h0);
      check("reset wdata", axi.M_AXI_WDATA, 32'h0);
      check("reset rsp_data", rsp_data, 32'h0);
      RSTn = 1'b1;
      #1;
      check("cmd_ready after reset", 32'(cmd_ready), 32'h1);

      // READ x5
      ar0 = ar_cnt; aw0 = aw_cnt;
      run_cmd(OP_READ, 32'h0000_0005, 32'h0, 32'h0, 0, d, e, to, held);
      check("read x5 timeout", 32'(to), 32'h0);
      check("read x5 data", d, 32'hDEAD_BEEF);
      check("read x5 err", 32'(e), 32'h0);
      check("read x5 ar count", 32'(ar_cnt - ar0), 32'd1);
      check("read x5 aw count", 32'(aw_cnt - aw0), 32'd0);
      check("read x5 araddr", last_araddr, 32'h4000_0005);
      check("rsp dropped after ready", 32'(rsp_valid), 32'h0);

      // FLIP x7 with mask 1, then read back
      aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
      run_cmd(OP_FLIP, 32'h0000_0007, 32'h0, 32'h0000_0001, 0, d, e, to, held);
      check("flip x7 data", d, 32'h0000_00F0);
      check("flip x7 err", 32'(e), 32'h0);
      check("flip x7 aw count", 32'(aw_cnt - aw0), 32'd1);
      check("flip x7 w count", 32'(w_cnt - w0), 32'd1);
      check("flip x7 b count", 32'(b_cnt - b0), 32'd1);
      run_cmd(OP_READ, 32'h0000_0007, 32'h0, 32'h0, 0, d, e, to, held);
      check("read x7 after flip", d, 32'h0000_00F1);

      // WRITE x0 is refused; x0 still reads 0
      run_cmd(OP_WRITE, 32'h0000_0000, 32'h1234_5678, 32'h0, 0, d, e, to, held);
      check("write x0 err", 32'(e), 32'h1);
      check("write x0 data", d, 32'h0);
      run_cmd(OP_READ, 32'h0000_0000, 32'h0, 32'h0, 0, d, e, to, held);
      check("read x0 data", d, 32'h0);
      check("read x0 err", 32'(e), 32'h0);

      // FLIP on PC selector: read errors, write skipped
      ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
      run_cmd(OP_FLIP, 32'h0000_0100, 32'h0, 32'hFFFF_FFFF, 0, d, e, to, held);
      check("flip pc err", 32'(e), 32'h1);
      check("flip pc data", d, PC_VALUE);
      check("flip pc ar count", 32'(ar_cnt - ar0), 32'd1);
      check("flip pc aw count", 32'(aw_cnt - aw0), 32'd0);
      check("flip pc w count", 32'(w_cnt - w0), 32'd0);

      // Reserved op: error response, no bus traffic
      ar0 = ar_cnt; aw0 = aw_cnt;
      run_cmd(OP_RSVD, 32'h0000_0005, 32'h0, 32'h0, 0, d, e, to, held);
      check("rsvd timeout", 32'(to), 32'h0);
      check("rsvd err", 32'(e), 32'h1);
      check("rsvd data", d, 32'h0);
      check("rsvd ar count", 32'(ar_cnt - ar0), 32'd0);
      check("rsvd aw count", 32'(aw_cnt - aw0), 32'd0);

      // WRITE x9 with AWREADY late, WREADY prompt, response consumed 5 cycles late
      aw_hold = 3; w_hold = 1; b0 = b_cnt;
      run_cmd(OP_WRITE, 32'h0000_0009, 32'hCAFE_0009, 32'h0, 5, d, e, to, held);
      aw_hold = 1;
      check("slow aw err", 32'(e), 32'h0);
      check("slow aw data", d, 32'h0);
      check("slow aw awvalid cycles", 32'(aw_last_cycles), 32'd3);
      check("slow aw wvalid cycles", 32'(w_last_cycles), 32'd1);
      check("slow aw b count", 32'(b_cnt - b0), 32'd1);
      check("rsp held until ready", 32'(held), 32'h1);
      run_cmd(OP_READ, 32'h0000_0009, 32'h0, 32'h0, 0, d, e, to, held);
      check("read x9", d, 32'hCAFE_0009);

      // Reset while waiting in RD_DATA
      r_hold = 1'b1; r0 = r_cnt;
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 32'h0000_0005;
      @(negedge CLK);
      cmd_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (axi.M_AXI_RREADY) begin
            seen = 1;
            break;
         end
         @(negedge CLK);
      end
      check("reached rd_data", 32'(seen), 32'd1);
      #2 RSTn = 1'b0;
      #1;
      check("async reset valids", valids(), 32'h0);
      check("async reset cmd_ready", 32'(cmd_ready), 32'h0);
      check("async reset araddr", axi.M_AXI_ARADDR, 32'h0);
      r_hold = 1'b0;
      repeat (2) @(negedge CLK);
      #2 RSTn = 1'b1;
      #1;
      check("cmd_ready after mid reset", 32'(cmd_ready), 32'h1);
      seen = 0;
      repeat (5) begin
         @(negedge CLK);
         if (rsp_valid) seen++;
      end
      check("no rsp for aborted read", 32'(seen), 32'd0);
      check("no r transfer after abort", 32'(r_cnt - r0), 32'd0);
      run_cmd(OP_READ, 32'h0000_0005, 32'h0, 32'h0, 0, d, e, to, held);
      check("read after reset timeout", 32'(to), 32'h0);
      check("read after reset data", d, 32'hDEAD_BEEF);
      check("read after reset err", 32'(e), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fault_inject_master.md
FAULT_INJECT_MASTER -- requirements
Module: fault_inject_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0000, OR'd into every issued AXI address.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RSTn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command request; cmd_ready  output  1  command accepted.
REQ-005 SHALL have port cmd_op  input  2  operation: 0 READ, 1 WRITE, 2 FLIP (read-XOR-write), 3 reserved.
REQ-006 SHALL have port cmd_addr  input  AXI_ADDR_WIDTH  target address, with bits [15:8] = sub-selector and bits [7:0] = sub-address.
REQ-007 SHALL have port cmd_wdata  input  DATA_WIDTH  WRITE data; cmd_mask  input  DATA_WIDTH  FLIP XOR mask.
REQ-008 SHALL have port rsp_valid  output  1  response; rsp_ready  input  1  response consumed.
REQ-009 SHALL have port rsp_data  output  DATA_WIDTH  read data (READ/FLIP: original value; WRITE: 0); rsp_err  output  1  error flag.
REQ-010 SHALL have full AXI4-Lite master ports M_AXI_AW*/W*/B*/AR*/R*, mirroring the slave widths from axi_configuration.vh.

Function
REQ-011 SHALL use the states IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP and RSP.
REQ-012 SHALL assert cmd_ready only in IDLE; on a cmd_valid&&cmd_ready handshake it SHALL latch op, addr, wdata and mask.
REQ-013 SHALL transition IDLE->RD_ADDR on accepting a READ or FLIP command, IDLE->WR_ADDR_DATA on WRITE, and IDLE->RSP with rsp_err=1 and rsp_data=0 on op 3, issuing no AXI traffic for op 3.
REQ-014 SHALL assert ARVALID in RD_ADDR with ARADDR = latched addr | BASE_ADDR and ARPROT = 0, and SHALL hold ARVALID and ARADDR stable until ARREADY.
REQ-015 SHALL assert RREADY only in RD_DATA; on RVALID it SHALL capture RDATA and RRESP.
REQ-016 SHALL, for READ, go RD_DATA->RSP with rsp_err = (RRESP != OKAY).
REQ-017 SHALL, for FLIP with RRESP = OKAY, go to WR_ADDR_DATA with write data = RDATA ^ mask.
REQ-018 SHALL, for FLIP with RRESP != OKAY, skip the write, go to RSP with rsp_err=1, and set rsp_data = captured RDATA.
REQ-019 SHALL assert AWVALID and WVALID together in WR_ADDR_DATA, with WSTRB all ones and AWPROT = 0.
REQ-020 SHALL deassert each of AWVALID and WVALID independently after its own handshake, and SHALL leave WR_ADDR_DATA only when both handshakes are done; the two handshakes may occur in the same cycle or in either order.
REQ-021 SHALL assert BREADY only in WR_RESP; on BVALID it SHALL go to RSP with rsp_err = (BRESP != OKAY).
REQ-022 SHALL assert rsp_valid only in RSP and hold rsp_data and rsp_err stable until rsp_ready, then return to IDLE.
REQ-023 SHALL have no command queue; at most one transaction is outstanding.
REQ-024 SHALL NOT raise a new VALID in the same cycle as the READY of the preceding channel: each channel step costs at least one registered cycle.
REQ-025 SHALL drive every AXI output and every response output from a register, never combinationally from an input.

Reset
REQ-026 SHALL, while RSTn=0, immediately drive state=IDLE and ARVALID, RREADY, AWVALID, WVALID, BREADY, rsp_valid and rsp_err to 0.
REQ-027 SHALL, while RSTn=0, drive all data and address outputs to 0 and cmd_ready to 0.
REQ-028 SHALL assert cmd_ready in the first cycle after RSTn rises.
REQ-029 SHALL abandon any transaction in progress when reset occurs mid-operation and SHALL produce no response for it.

Structure
REQ-030 SHALL place the op codes, state encodings and sub-selector constants (REGISTER_FILE=8'h00, PC=8'h01) in axi_configuration.vh for sharing with the slave.
REQ-031 SHALL be a single flat module with no sub-module.

Verification
REQ-032 SHALL verify READ: slave regfile x5=32'hDEAD_BEEF, READ addr 16'h0005 -> rsp_data=32'hDEAD_BEEF, rsp_err=0, exactly one AR transfer.
REQ-033 SHALL verify FLIP: x7=32'h0000_00F0, mask=32'h0000_0001 -> rsp_data=32'h0000_00F0, rsp_err=0, and a subsequent READ of x7 returns 32'h0000_00F1.
REQ-034 SHALL verify WRITE to x0 (addr 16'h0000), data 32'h1234_5678 -> rsp_err=1 (SLVERR), and a READ of x0 returns 0.
REQ-035 SHALL verify FLIP on PC selector addr 16'h0100 -> read SLVERR, rsp_err=1, and no AW or W handshake occurs.
REQ-036 SHALL verify a slave with AWREADY delayed 3 cycles and WREADY delayed 0 cycles -> AWVALID held for 3 cycles, WVALID dropped after 1 cycle, exactly one B transfer, and rsp_valid held until rsp_ready is asserted 5 cycles later.
REQ-037 SHALL verify RSTn asserted in RD_DATA -> all VALID outputs 0 asynchronously, no response produced, and the next READ completes normally.
